// File: rtl/decode_stage.sv
// decode_stage: ID stage of the pipelined MIPS core.
// Decodes the IF/ID instruction and reads the 32x32 register file, which has a WB write-through
// path. Branches and jumps are resolved here, and the fetch-control outputs are driven from here.
// This stage also owns the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IFIDinstruction,
    input  logic [31:0] IFIDpcPlusFour,
    input  logic        WBRegWrite,
    input  logic [4:0]  WBWriteReg,
    input  logic [31:0] WBWriteData,
    input  logic        EXMEMRegWrite,
    input  logic [4:0]  EXMEMWriteReg,
    output logic [31:0] BranchAdress,
    output logic        MuxBranchControl,
    output logic        Flush,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic [31:0] IDEXReadData1,
    output logic [31:0] IDEXReadData2,
    output logic [31:0] IDEXImm,
    output logic [4:0]  IDEXRs,
    output logic [4:0]  IDEXRt,
    output logic [4:0]  IDEXRd,
    output logic        IDEXRegDst,
    output logic        IDEXALUSrc,
    output logic        IDEXMemRead,
    output logic        IDEXMemWrite,
    output logic        IDEXMemToReg,
    output logic        IDEXRegWrite,
    output logic [1:0]  IDEXALUOp
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext;
    logic [31:0] br_target, j_target;
    logic        is_beq, is_bne, is_j;

    assign op        = IFIDinstruction[31:26];
    assign rs        = IFIDinstruction[25:21];
    assign rt        = IFIDinstruction[20:16];
    assign rd        = IFIDinstruction[15:11];
    assign imm_sext  = {{16{IFIDinstruction[15]}}, IFIDinstruction[15:0]};
    assign br_target = IFIDpcPlusFour + {imm_sext[29:0], 2'b00};
    assign j_target  = {IFIDpcPlusFour[31:28], IFIDinstruction[25:0], 2'b00};
    assign is_beq    = (op == OP_BEQ);
    assign is_bne    = (op == OP_BNE);
    assign is_j      = (op == OP_J);

    logic [31:0] rf_q [32];
    logic [31:0] rdata1, rdata2;

    // Register file write port from WB; $0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (WBRegWrite && (WBWriteReg != '0)) begin
            rf_q[WBWriteReg] <= WBWriteData;
        end
    end

    // Register reads: $0 is hard zero, and a same-cycle WB write is forwarded.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs != '0) rdata1 = (WBRegWrite && (WBWriteReg == rs)) ? WBWriteData : rf_q[rs];
        if (rt != '0) rdata2 = (WBRegWrite && (WBWriteReg == rt)) ? WBWriteData : rf_q[rt];
    end

    logic       c_regdst, c_alusrc, c_memread, c_memwrite, c_memtoreg, c_regwrite;
    logic [1:0] c_aluop;
    logic       uses_rt;

    // Main control decode. The all-zero instruction and unknown opcodes decode as bubbles.
    always_comb begin
        c_regdst   = 1'b0;
        c_alusrc   = 1'b0;
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_memtoreg = 1'b0;
        c_regwrite = 1'b0;
        c_aluop    = 2'b00;
        uses_rt    = 1'b0;
        if (IFIDinstruction != '0) begin
            case (op)
                OP_RTYPE: begin
                    c_regdst   = 1'b1;
                    c_aluop    = 2'b10;
                    c_regwrite = (rd != '0);
                    uses_rt    = 1'b1;
                end
                OP_LW: begin
                    c_alusrc   = 1'b1;
                    c_memread  = 1'b1;
                    c_memtoreg = 1'b1;
                    c_regwrite = (rt != '0);
                end
                OP_SW: begin
                    c_alusrc   = 1'b1;
                    c_memwrite = 1'b1;
                    uses_rt    = 1'b1;
                end
                OP_ADDI: begin
                    c_alusrc   = 1'b1;
                    c_regwrite = (rt != '0);
                end
                OP_BEQ, OP_BNE: uses_rt = 1'b1;
                default: ;
            endcase
        end
    end

    logic [31:0] rd1_q, rd2_q, imm_q, rd1_d, rd2_d, imm_d;
    logic [4:0]  rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
    logic        regdst_q, alusrc_q, memread_q, memwrite_q, memtoreg_q, regwrite_q;
    logic        regdst_d, alusrc_d, memread_d, memwrite_d, memtoreg_d, regwrite_d;
    logic [1:0]  aluop_q, aluop_d;
    logic [4:0]  ex_dest;
    logic        load_use, br_stall, stall, redirect;

    assign ex_dest = regdst_q ? rd_q : rt_q;

    // Hazard detection: load-use on the instruction in EX, and branch operands still in flight.
    always_comb begin
        load_use = memread_q && (rt_q != '0) &&
                   ((rt_q == rs) || (uses_rt && (rt_q == rt)));
        br_stall = 1'b0;
        if (is_beq || is_bne) begin
            br_stall = ((rs != '0) && ((regwrite_q && (ex_dest == rs)) ||
                                       (EXMEMRegWrite && (EXMEMWriteReg == rs)))) ||
                       ((rt != '0) && ((regwrite_q && (ex_dest == rt)) ||
                                       (EXMEMRegWrite && (EXMEMWriteReg == rt))));
        end
        stall    = load_use || br_stall;
        redirect = !stall && (is_j || (is_beq && (rdata1 == rdata2)) ||
                                      (is_bne && (rdata1 != rdata2)));
    end

    // Fetch control. Everything is held low while in reset; stall wins over redirect.
    always_comb begin
        PCWrite          = 1'b0;
        IFIDWrite        = 1'b0;
        Flush            = 1'b0;
        MuxBranchControl = 1'b0;
        BranchAdress     = '0;
        if (rst_n) begin
            if (is_beq || is_bne) BranchAdress = br_target;
            else if (is_j)        BranchAdress = j_target;
            if (!stall) begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
                if (redirect) begin
                    Flush            = 1'b1;
                    MuxBranchControl = 1'b1;
                end
            end
        end
    end

    // ID/EX next state. Stalls and taken branches or jumps insert a fully zeroed bubble.
    always_comb begin
        rd1_d = '0; rd2_d = '0; imm_d = '0;
        rs_d  = '0; rt_d  = '0; rd_d  = '0;
        regdst_d = 1'b0; alusrc_d = 1'b0; memread_d = 1'b0;
        memwrite_d = 1'b0; memtoreg_d = 1'b0; regwrite_d = 1'b0;
        aluop_d = 2'b00;
        if (!stall && !redirect) begin
            rd1_d = rdata1; rd2_d = rdata2; imm_d = imm_sext;
            rs_d  = rs;     rt_d  = rt;     rd_d  = rd;
            regdst_d = c_regdst; alusrc_d = c_alusrc; memread_d = c_memread;
            memwrite_d = c_memwrite; memtoreg_d = c_memtoreg; regwrite_d = c_regwrite;
            aluop_d = c_aluop;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
            rs_q  <= '0; rt_q  <= '0; rd_q  <= '0;
            regdst_q <= 1'b0; alusrc_q <= 1'b0; memread_q <= 1'b0;
            memwrite_q <= 1'b0; memtoreg_q <= 1'b0; regwrite_q <= 1'b0;
            aluop_q <= 2'b00;
        end else begin
            rd1_q <= rd1_d; rd2_q <= rd2_d; imm_q <= imm_d;
            rs_q  <= rs_d;  rt_q  <= rt_d;  rd_q  <= rd_d;
            regdst_q <= regdst_d; alusrc_q <= alusrc_d; memread_q <= memread_d;
            memwrite_q <= memwrite_d; memtoreg_q <= memtoreg_d; regwrite_q <= regwrite_d;
            aluop_q <= aluop_d;
        end
    end

    assign IDEXReadData1 = rd1_q;
    assign IDEXReadData2 = rd2_q;
    assign IDEXImm       = imm_q;
    assign IDEXRs        = rs_q;
    assign IDEXRt        = rt_q;
    assign IDEXRd        = rd_q;
    assign IDEXRegDst    = regdst_q;
    assign IDEXALUSrc    = alusrc_q;
    assign IDEXMemRead   = memread_q;
    assign IDEXMemWrite  = memwrite_q;
    assign IDEXMemToReg  = memtoreg_q;
    assign IDEXRegWrite  = regwrite_q;
    assign IDEXALUOp     = aluop_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference model fills expectation queues,
// and monitors pop them and compare against the DUT outputs each cycle.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IFIDinstruction = '0, IFIDpcPlusFour = '0;
    logic        WBRegWrite = 1'b0;
    logic [4:0]  WBWriteReg = '0;
    logic [31:0] WBWriteData = '0;
    logic        EXMEMRegWrite = 1'b0;
    logic [4:0]  EXMEMWriteReg = '0;
    logic [31:0] BranchAdress;
    logic        MuxBranchControl, Flush, PCWrite, IFIDWrite;
    logic [31:0] IDEXReadData1, IDEXReadData2, IDEXImm;
    logic [4:0]  IDEXRs, IDEXRt, IDEXRd;
    logic        IDEXRegDst, IDEXALUSrc, IDEXMemRead, IDEXMemWrite, IDEXMemToReg, IDEXRegWrite;
    logic [1:0]  IDEXALUOp;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .IFIDinstruction(IFIDinstruction), .IFIDpcPlusFour(IFIDpcPlusFour),
        .WBRegWrite(WBRegWrite), .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
        .EXMEMRegWrite(EXMEMRegWrite), .EXMEMWriteReg(EXMEMWriteReg),
        .BranchAdress(BranchAdress), .MuxBranchControl(MuxBranchControl), .Flush(Flush),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEXReadData1(IDEXReadData1), .IDEXReadData2(IDEXReadData2), .IDEXImm(IDEXImm),
        .IDEXRs(IDEXRs), .IDEXRt(IDEXRt), .IDEXRd(IDEXRd),
        .IDEXRegDst(IDEXRegDst), .IDEXALUSrc(IDEXALUSrc), .IDEXMemRead(IDEXMemRead),
        .IDEXMemWrite(IDEXMemWrite), .IDEXMemToReg(IDEXMemToReg), .IDEXRegWrite(IDEXRegWrite),
        .IDEXALUOp(IDEXALUOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        pcw, ifidw, flush, mux;
        bit [31:0] badr;
    } comb_t;

    typedef struct {
        bit [31:0] rd1, rd2, imm;
        bit [4:0]  rs, rt, rd;
        bit        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
        bit [1:0]  aluop;
        bit        chk_data;
    } idex_t;

    comb_t comb_q[$];
    idex_t idex_q[$];
    int    total = 0;
    int    bad = 0;

    // Reference model state: architectural registers, ID/EX contents, and the EX/MEM destination.
    bit [31:0] m_rf[32];
    idex_t     m_idex;
    bit        m_exmem_rw;
    bit [4:0]  m_exmem_reg;
    bit        last_stall, last_redirect;

    // A WB write can be scheduled a given number of steps ahead, or generated at random.
    int        wb_delay = 0;
    bit [4:0]  wb_reg_s;
    bit [31:0] wb_data_s;
    bit        rand_wb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] mread(input bit [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (WBRegWrite && WBWriteReg == r) return WBWriteData;
        return m_rf[r];
    endfunction

    function automatic bit [31:0] rtype(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] o, input bit [4:0] s, input bit [4:0] t,
                                        input bit [15:0] im);
        return {o, s, t, im};
    endfunction

    // One clock cycle: drive IF/ID, predict the cycle's behaviour, push expectations, and advance the model.
    task automatic step(input bit [31:0] ins, input bit [31:0] pc4, input bit rst);
        bit [5:0]  op;
        bit [4:0]  rs, rt, rd;
        bit [31:0] sx, a, b;
        bit        isbr, jmp, taken, stall;
        bit [4:0]  srcs[$];
        bit [4:0]  pend[$];
        comb_t     c;
        idex_t     dec, n;

        rst_n           = rst;
        IFIDinstruction = ins;
        IFIDpcPlusFour  = pc4;
        EXMEMRegWrite   = m_exmem_rw;
        EXMEMWriteReg   = m_exmem_reg;
        if (wb_delay == 1) begin
            WBRegWrite = 1'b1; WBWriteReg = wb_reg_s; WBWriteData = wb_data_s;
        end else if (rand_wb && $urandom_range(2) == 0) begin
            WBRegWrite = 1'b1; WBWriteReg = 5'($urandom_range(7)); WBWriteData = $urandom;
        end else begin
            WBRegWrite = 1'b0; WBWriteReg = 5'($urandom_range(31)); WBWriteData = $urandom;
        end
        if (wb_delay > 0) wb_delay--;

        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sx = {{16{ins[15]}}, ins[15:0]};
        a = mread(rs);
        b = mread(rt);
        isbr = (op == 6'h04) || (op == 6'h05);
        jmp  = (op == 6'h02);

        // Decoded instruction, according to the opcode table.
        dec = '{default: 0};
        dec.rd1 = a; dec.rd2 = b; dec.imm = sx; dec.rs = rs; dec.rt = rt; dec.rd = rd;
        dec.chk_data = 1'b1;
        if (ins != 32'd0) begin
            case (op)
                6'h00: begin dec.regdst = 1; dec.aluop = 2'b10; dec.regwrite = 1; end
                6'h23: begin dec.alusrc = 1; dec.memread = 1; dec.memtoreg = 1; dec.regwrite = 1; end
                6'h2B: begin dec.alusrc = 1; dec.memwrite = 1; end
                6'h08: begin dec.alusrc = 1; dec.regwrite = 1; end
                default: ;
            endcase
        end
        if ((dec.regdst ? rd : rt) == 5'd0) dec.regwrite = 1'b0;

        // Hazards: the source registers this instruction reads, and the destinations still in flight.
        stall = 1'b0;
        srcs.push_back(rs);
        if (op == 6'h00 || isbr || op == 6'h2B) srcs.push_back(rt);
        if (m_idex.memread && m_idex.rt != 0)
            foreach (srcs[i]) if (srcs[i] == m_idex.rt) stall = 1'b1;
        if (m_idex.regwrite) pend.push_back(m_idex.regdst ? m_idex.rd : m_idex.rt);
        if (m_exmem_rw) pend.push_back(m_exmem_reg);
        if (isbr)
            foreach (pend[i]) if (pend[i] != 0 && (pend[i] == rs || pend[i] == rt)) stall = 1'b1;

        taken = !stall && (jmp || (op == 6'h04 && a == b) || (op == 6'h05 && a != b));

        c = '{default: 0};
        c.rst = rst;
        if (rst) begin
            c.badr  = isbr ? pc4 + (sx << 2) : (jmp ? {pc4[31:28], ins[25:0], 2'b00} : 32'd0);
            c.pcw   = !stall;
            c.ifidw = !stall;
            c.flush = taken;
            c.mux   = taken;
        end

        n = '{default: 0};
        n.chk_data = 1'b1;
        if (rst && !stall) begin
            if (taken) n.chk_data = 1'b0;
            else       n = dec;
        end
        comb_q.push_back(c);
        idex_q.push_back(n);

        if (!rst) begin
            foreach (m_rf[i]) m_rf[i] = 32'd0;
        end else if (WBRegWrite && WBWriteReg != 0) begin
            m_rf[WBWriteReg] = WBWriteData;
        end
        m_exmem_rw    = rst && m_idex.regwrite;
        m_exmem_reg   = m_idex.regdst ? m_idex.rd : m_idex.rt;
        m_idex        = n;
        last_stall    = stall;
        last_redirect = taken;

        @(posedge clk);
        #2;
    endtask

    // Presents an instruction as IF/ID would: it is held through stalls, and a redirect is followed by a flushed slot.
    task automatic issue(input bit [31:0] ins, input bit [31:0] pc4);
        int n = 0;
        step(ins, pc4, 1'b1);
        while (last_stall && n < 8) begin
            step(ins, pc4, 1'b1);
            n++;
        end
        if (last_stall) begin
            total++; bad++;
            $display("FAIL stall_bound: still stalled after %0d cycles, expected release", n);
        end
        if (last_redirect) step(32'h0, pc4 + 32'd4, 1'b1);
    endtask

    // Monitor for the combinational fetch-control outputs, sampled mid-cycle.
    always @(negedge clk) begin : mon_comb
        comb_t e;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            chk("PCWrite", 32'(PCWrite), 32'(e.pcw));
            chk("IFIDWrite", 32'(IFIDWrite), 32'(e.ifidw));
            chk("Flush", 32'(Flush), 32'(e.flush));
            chk("MuxBranchControl", 32'(MuxBranchControl), 32'(e.mux));
            chk("BranchAdress", BranchAdress, e.badr);
            if (!e.rst)
                chk("IDEX_async_clear",
                    32'(IDEXReadData1 | IDEXReadData2 | IDEXImm) |
                    32'({IDEXRs, IDEXRt, IDEXRd, IDEXRegDst, IDEXALUSrc, IDEXMemRead,
                         IDEXMemWrite, IDEXMemToReg, IDEXRegWrite, IDEXALUOp}), 32'd0);
        end
    end

    // Monitor for the ID/EX register, sampled just after the edge that loads it.
    always @(posedge clk) begin : mon_idex
        idex_t e;
        #1;
        if (idex_q.size() > 0) begin
            e = idex_q.pop_front();
            chk("IDEX_ctrl",
                {24'd0, IDEXRegDst, IDEXALUSrc, IDEXMemRead, IDEXMemWrite, IDEXMemToReg,
                 IDEXRegWrite, IDEXALUOp},
                {24'd0, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.aluop});
            if (e.chk_data) begin
                chk("IDEXReadData1", IDEXReadData1, e.rd1);
                chk("IDEXReadData2", IDEXReadData2, e.rd2);
                chk("IDEXImm", IDEXImm, e.imm);
                chk("IDEX_regs", {17'd0, IDEXRs, IDEXRt, IDEXRd}, {17'd0, e.rs, e.rt, e.rd});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit [5:0]  ops[8];
        bit [5:0]  o;
        bit [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F};
        m_idex = '{default: 0};
        m_exmem_rw = 1'b0; m_exmem_reg = '0;
        foreach (m_rf[i]) m_rf[i] = 32'd0;

        @(posedge clk);
        #2;
        // Reset with an all-ones instruction in IF/ID, then release on a nop.
        step(32'hFFFF_FFFF, 32'h4, 1'b0);
        step(32'hFFFF_FFFF, 32'h4, 1'b0);
        step(32'h0, 32'h4, 1'b1);

        // WB write-through: $5 = 0x1234 while add $3,$5,$0 is being decoded.
        wb_delay = 1; wb_reg_s = 5'd5; wb_data_s = 32'h1234;
        issue(rtype(5, 0, 3), 32'h8);

        // Load-use: lw $2,0($1) followed by add $4,$2,$3.
        issue(itype(6'h23, 1, 2, 16'h0), 32'hC);
        issue(rtype(2, 3, 4), 32'h10);

        // beq $1,$1,+3 is taken; bne $1,$1 is not.
        issue(itype(6'h04, 1, 1, 16'd3), 32'h100);
        issue(itype(6'h05, 1, 1, 16'd3), 32'h100);

        // addi $7,$0,5 then beq $7,$0,-1: two stall cycles, and the result reaches WB on the third.
        issue(itype(6'h08, 0, 7, 16'd5), 32'h200);
        wb_delay = 3; wb_reg_s = 5'd7; wb_data_s = 32'd5;
        issue(itype(6'h04, 7, 0, 16'hFFFF), 32'h100);

        // Jump with the upper PC bits preserved.
        issue({6'h02, 26'h40}, 32'hA000_0004);

        // A write to $0 is ignored.
        wb_delay = 1; wb_reg_s = 5'd0; wb_data_s = 32'hDEAD;
        issue(rtype(0, 0, 8), 32'h300);
        issue(rtype(0, 0, 9), 32'h304);

        // Reset asserted during a load-use stall, then released.
        issue(itype(6'h23, 1, 2, 16'h4), 32'h400);
        step(rtype(2, 3, 4), 32'h404, 1'b0);
        step(32'h0, 32'h404, 1'b1);

        // Random instruction mix over a small register window, so hazards occur often.
        rand_wb = 1'b1;
        for (int k = 0; k < 300; k++) begin
            o = ops[$urandom_range(7)];
            if (o == 6'h02)
                ins = {o, 26'($urandom)};
            else if (o == 6'h00)
                ins = {o, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                       5'd0, 6'($urandom)};
            else
                ins = {o, 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom)};
            issue(ins, {$urandom} & 32'hFFFF_FFFC);
        end
        rand_wb = 1'b0;
        step(32'h0, 32'h0, 1'b1);
        step(32'h0, 32'h0, 1'b1);

        chk("queues_drained", 32'(comb_q.size() + idex_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
